// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating one interconnect port on a single-port synchronous SRAM.
// Optional macro SLV_WR_PRIO_EN: write address wins over read address when both arrive in IDLE.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_sram_slave #(
  parameter int SRAM_AW = 14,
  parameter int DATA_W  = `AXI_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  // read address
  input  logic [`AXI_IDS_BITS-1:0] ARID,
  input  logic [31:0]              ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  // read data
  output logic [`AXI_IDS_BITS-1:0] RID,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  // write address
  input  logic [`AXI_IDS_BITS-1:0] AWID,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  // write data
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [DATA_W/8-1:0]      WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  // write response
  output logic [`AXI_IDS_BITS-1:0] BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  // SRAM macro
  output logic                     CS,
  output logic                     OE,
  output logic [DATA_W-1:0]        WEB,
  output logic [SRAM_AW-1:0]       A,
  output logic [DATA_W-1:0]        DI,
  input  logic [DATA_W-1:0]        DO
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t                   state;
  logic [`AXI_IDS_BITS-1:0] id;
  logic [SRAM_AW-1:0]       addr;
  logic [3:0]               len;
  logic [3:0]               cnt;
  logic                     err;
  logic                     last_beat;
  logic                     ar_hs;
  logic                     aw_hs;

  // Burst type and size are not decoded: every burst is INCR with 4-byte beats.
  logic unused;
  assign unused = ^{ARSIZE, ARBURST, AWSIZE, AWBURST,
                    ARADDR[31:SRAM_AW+2], ARADDR[1:0],
                    AWADDR[31:SRAM_AW+2], AWADDR[1:0]};

  assign last_beat = (cnt == len);
  assign ar_hs     = ARVALID & ARREADY;
  assign aw_hs     = AWVALID & AWREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id    <= '0;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            id    <= ARID;
            addr  <= ARADDR[SRAM_AW+1:2];
            len   <= ARLEN;
            cnt   <= '0;
            state <= RD_ISSUE;
          end else if (aw_hs) begin
            id    <= AWID;
            addr  <= AWADDR[SRAM_AW+1:2];
            len   <= AWLEN;
            cnt   <= '0;
            err   <= 1'b0;
            state <= WR_DATA;
          end
        end
        RD_ISSUE: state <= RD_DATA;
        RD_DATA: begin
          if (RREADY) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              cnt   <= cnt + 4'd1;
              addr  <= addr + SRAM_AW'(1);
              state <= RD_ISSUE;
            end
          end
        end
        WR_DATA: begin
          if (WVALID) begin
            // An early WLAST or a missing one both close the burst and flag SLVERR.
            if (WLAST || last_beat) begin
              err   <= (WLAST != last_beat);
              state <= WR_RESP;
            end else begin
              cnt  <= cnt + 4'd1;
              addr <= addr + SRAM_AW'(1);
            end
          end
        end
        WR_RESP: if (BREADY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ARREADY = 1'b0;
    AWREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = 2'b00;
    CS      = 1'b0;
    OE      = 1'b0;
    WEB     = '1;
    DI      = '0;
    case (state)
      IDLE: begin
`ifdef SLV_WR_PRIO_EN
        ARREADY = ~AWVALID;
        AWREADY = 1'b1;
`else
        ARREADY = 1'b1;
        AWREADY = ~ARVALID;
`endif
      end
      RD_ISSUE: begin
        CS = 1'b1;
        OE = 1'b1;
      end
      // CS stays low here so DO holds the beat while RREADY is stalled.
      RD_DATA: begin
        RVALID = 1'b1;
        RLAST  = last_beat;
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          CS = 1'b1;
          DI = WDATA;
          for (int i = 0; i < DATA_W/8; i++) WEB[8*i +: 8] = {8{~WSTRB[i]}};
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        BRESP  = err ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  assign RDATA = DO;
  assign RRESP = 2'b00;
  assign RID   = id;
  assign BID   = id;
  assign A     = addr;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave with a behavioural SRAM macro and reference memory.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  ARID, RID, AWID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA, WEB, DI, DO;
  logic [3:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
  logic        WLAST, WVALID, WREADY, BVALID, BREADY, CS, OE;
  logic [AW-1:0] A;

  axi_sram_slave #(.SRAM_AW(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  // Behavioural SRAM: read data registered, per-bit active-low write enable.
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (CS) begin
      if (OE) DO <= mem[A];
      else    mem[A] <= (mem[A] & WEB) | (DI & ~WEB);
    end
  end

  logic [AW-1:0] rd_addr_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_web_q[$];
  always @(negedge clk) begin
    if (!rst && CS) begin
      if (OE) rd_addr_q.push_back(A);
      else begin
        wr_addr_q.push_back(A);
        wr_web_q.push_back(WEB);
      end
    end
  end

  logic [31:0] exp_q[$], got_q[$];
  logic        exp_last_q[$], got_last_q[$];
  int compared = 0, mismatched = 0;
  logic [1:0] b_resp;
  logic [7:0] b_id, r_id;
  int b_wait, first_lat, stall_bad;

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic settle(); #1; endtask

  task automatic clear_mon();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_web_q.delete();
    exp_q.delete(); got_q.delete(); exp_last_q.delete(); got_last_q.delete();
  endtask

  task automatic bound_fail(input string what);
    compared++; mismatched++;
    $display("FAIL timeout_%s: handshake never came, required within 50 cycles", what);
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats, input int wlast_at, input logic [31:0] d0,
                           input logic [3:0] strb);
    int n;
    logic [AW-1:0] wa;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    settle();
    n = 0; while (!AWREADY && n < 50) begin tick(); settle(); n++; end
    if (n >= 50) bound_fail("aw");
    tick(); AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wa = addr[AW+1:2] + AW'(i);
      WVALID = 1'b1; WDATA = d0 + 32'(i); WSTRB = strb; WLAST = (i == wlast_at);
      settle();
      n = 0; while (!WREADY && n < 50) begin tick(); settle(); n++; end
      if (n >= 50) bound_fail("w");
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[wa][8*b +: 8] = WDATA[8*b +: 8];
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    settle();
    b_wait = 0; while (!BVALID && b_wait < 50) begin tick(); settle(); b_wait++; end
    if (b_wait >= 50) bound_fail("b");
    b_resp = BRESP; b_id = BID;
    BREADY = 1'b1; tick(); BREADY = 1'b0; settle();
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int stall_beat, input int stall_cyc);
    int n;
    logic [31:0] hold;
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(ref_mem[addr[AW+1:2] + AW'(i)]);
      exp_last_q.push_back(i == int'(len));
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    settle();
    n = 0; while (!ARREADY && n < 50) begin tick(); settle(); n++; end
    if (n >= 50) bound_fail("ar");
    tick(); ARVALID = 1'b0; settle();
    first_lat = 1; stall_bad = 0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0; while (!RVALID && n < 50) begin tick(); settle(); n++; first_lat++; end
      if (n >= 50) bound_fail("r");
      if (i == 0) first_lat = first_lat - n + n;
      if (i == stall_beat) begin
        hold = RDATA;
        for (int k = 0; k < stall_cyc; k++) begin
          tick(); settle();
          if (RDATA !== hold || RVALID !== 1'b1 || CS !== 1'b0) stall_bad++;
        end
      end
      RREADY = 1'b1; settle();
      got_q.push_back(RDATA); got_last_q.push_back(RLAST); r_id = RID;
      tick(); RREADY = 1'b0; settle();
      if (i == 0) first_lat = -first_lat;
    end
    first_lat = -first_lat;
  endtask

  task automatic drain_sb(input string tag);
    logic [31:0] e, g;
    logic el, gl;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); el = exp_last_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin
        mismatched++;
        $display("FAIL %s_beat: no beat received, required data %h", tag, e);
      end else begin
        g = got_q.pop_front(); gl = got_last_q.pop_front();
        if (g !== e || gl !== el) begin
          mismatched++;
          $display("FAIL %s_beat: got data %h last %b, required data %h last %b", tag, g, gl, e, el);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); settle();
    compared++;
    if ({ARREADY, AWREADY, RVALID, BVALID, WREADY, RLAST, CS, OE} !== 8'b1100_0000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b, required 11000000",
               {ARREADY, AWREADY, RVALID, BVALID, WREADY, RLAST, CS, OE});
    end
    compared++;
    if (WEB !== 32'hFFFF_FFFF || A !== '0 || DI !== 32'h0 || RDATA !== DO) begin
      mismatched++;
      $display("FAIL reset_sram: got WEB %h A %h DI %h RDATA %h, required ffffffff 0 0 %h", WEB, A, DI, RDATA, DO);
    end
    compared++;
    if ({RID, BID, RRESP, BRESP} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_ids: got %h, required 0", {RID, BID, RRESP, BRESP});
    end
    rst = 1'b0; tick(); settle();
  endtask

  task automatic test_single();
    clear_mon();
    axi_write(8'h5A, 32'h0000_0010, 4'd0, 1, 0, 32'hDEAD_BEEF, 4'hF);
    compared++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== AW'(4) || wr_web_q[0] !== 32'h0) begin
      mismatched++;
      $display("FAIL single_wr_sram: got %0d writes A %h WEB %h, required 1 write A 0004 WEB 0",
               wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : '0, wr_web_q.size() ? wr_web_q[0] : '0);
    end
    compared++;
    if (b_resp !== 2'b00 || b_id !== 8'h5A || b_wait !== 0) begin
      mismatched++;
      $display("FAIL single_wr_b: got resp %b id %h wait %0d, required 00 5a 0", b_resp, b_id, b_wait);
    end
    axi_read(8'h33, 32'h0000_0010, 4'd0, -1, 0);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 32'hDEAD_BEEF || first_lat != 2 || r_id !== 8'h33) begin
      mismatched++;
      $display("FAIL single_rd: got data %h lat %0d id %h, required deadbeef 2 33",
               got_q.size() ? got_q[0] : '0, first_lat, r_id);
    end
    drain_sb("single");
    compared++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      mismatched++;
      $display("FAIL single_idle: got ARREADY %b RVALID %b, required 1 0", ARREADY, RVALID);
    end
  endtask

  task automatic test_partial();
    axi_write(8'h01, 32'h0000_0020, 4'd0, 1, 0, 32'h1122_3344, 4'hF);
    clear_mon();
    axi_write(8'h02, 32'h0000_0020, 4'd0, 1, 0, 32'hAABB_CCDD, 4'b0101);
    compared++;
    if (wr_web_q.size() != 1 || wr_web_q[0] !== 32'hFF00_FF00) begin
      mismatched++;
      $display("FAIL partial_web: got %h, required ff00ff00", wr_web_q.size() ? wr_web_q[0] : '0);
    end
    axi_read(8'h03, 32'h0000_0020, 4'd0, -1, 0);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 32'h11BB_33DD) begin
      mismatched++;
      $display("FAIL partial_merge: got %h, required 11bb33dd", got_q.size() ? got_q[0] : '0);
    end
    drain_sb("partial");
  endtask

  task automatic test_burst_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    clear_mon();
    axi_write(8'h10, 32'h0000_FFF8, 4'd3, 4, 3, 32'hA000_0000, 4'hF);
    compared++;
    if (wr_addr_q.size() != 4 || b_resp !== 2'b00) begin
      mismatched++;
      $display("FAIL burst_wr: got %0d writes resp %b, required 4 writes resp 00", wr_addr_q.size(), b_resp);
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (wr_addr_q[i] !== exp_a[i]) begin
          mismatched++;
          $display("FAIL burst_wr_addr%0d: got %h, required %h", i, wr_addr_q[i], exp_a[i]);
        end
      end
    end
    axi_read(8'h11, 32'h0000_FFF8, 4'd3, 1, 3);
    compared++;
    if (rd_addr_q.size() != 4) begin
      mismatched++;
      $display("FAIL burst_rd_cnt: got %0d reads, required 4", rd_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (rd_addr_q[i] !== exp_a[i]) begin
          mismatched++;
          $display("FAIL burst_rd_addr%0d: got %h, required %h", i, rd_addr_q[i], exp_a[i]);
        end
      end
    end
    compared++;
    if (stall_bad != 0) begin
      mismatched++;
      $display("FAIL burst_stall: got %0d unstable cycles, required 0", stall_bad);
    end
    drain_sb("burst");
  endtask

  task automatic test_arb();
    ARADDR = 32'h0; AWADDR = 32'h0; ARVALID = 1'b1; AWVALID = 1'b1;
    settle();
    compared++;
`ifdef SLV_WR_PRIO_EN
    if (ARREADY !== 1'b0 || AWREADY !== 1'b1) begin
      mismatched++;
      $display("FAIL arb: got ARREADY %b AWREADY %b, required 0 1", ARREADY, AWREADY);
    end
`else
    if (ARREADY !== 1'b1 || AWREADY !== 1'b0) begin
      mismatched++;
      $display("FAIL arb: got ARREADY %b AWREADY %b, required 1 0", ARREADY, AWREADY);
    end
`endif
    ARVALID = 1'b0; AWVALID = 1'b0; settle();
  endtask

  task automatic test_wlast_err();
    clear_mon();
    axi_write(8'h21, 32'h0000_0100, 4'd3, 2, 1, 32'h5555_0000, 4'hF);
    compared++;
    if (b_resp !== 2'b10 || wr_addr_q.size() != 2 || b_id !== 8'h21) begin
      mismatched++;
      $display("FAIL early_wlast: got resp %b writes %0d id %h, required 10 2 21", b_resp, wr_addr_q.size(), b_id);
    end
    clear_mon();
    axi_write(8'h22, 32'h0000_0200, 4'd1, 2, -1, 32'h6666_0000, 4'hF);
    compared++;
    if (b_resp !== 2'b10 || wr_addr_q.size() != 2) begin
      mismatched++;
      $display("FAIL missing_wlast: got resp %b writes %0d, required 10 2", b_resp, wr_addr_q.size());
    end
    compared++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      mismatched++;
      $display("FAIL wlast_idle: got AWREADY %b WREADY %b, required 1 0", AWREADY, WREADY);
    end
    axi_read(8'h23, 32'h0000_0200, 4'd1, -1, 0);
    drain_sb("errwr");
  endtask

  task automatic test_rst_mid();
    int n;
    clear_mon();
    axi_write(8'h30, 32'h0000_0400, 4'd3, 4, 3, 32'hC0DE_0000, 4'hF);
    ARID = 8'h31; ARADDR = 32'h0000_0400; ARLEN = 4'd3; ARVALID = 1'b1; settle();
    n = 0; while (!ARREADY && n < 50) begin tick(); settle(); n++; end
    if (n >= 50) bound_fail("rst_ar");
    tick(); ARVALID = 1'b0; settle();
    n = 0; while (!RVALID && n < 50) begin tick(); settle(); n++; end
    if (n >= 50) bound_fail("rst_r");
    rst = 1'b1; tick(); settle();
    compared++;
    if (RVALID !== 1'b0 || CS !== 1'b0 || ARREADY !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid: got RVALID %b CS %b ARREADY %b, required 0 0 1", RVALID, CS, ARREADY);
    end
    rst = 1'b0; tick(); settle();
    axi_read(8'h32, 32'h0000_0400, 4'd3, -1, 0);
    compared++;
    if (r_id !== 8'h32 || got_q.size() != 4) begin
      mismatched++;
      $display("FAIL rst_reread: got id %h beats %0d, required 32 4", r_id, got_q.size());
    end
    drain_sb("rstrd");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    DO = 32'h0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    test_reset();
    test_single();
    test_partial();
    test_burst_wrap();
    test_arb();
    test_wlast_err();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave that terminates one bus port of the interconnect on a single-port synchronous SRAM macro (instruction or data memory). It is the stage downstream of the CPU-side AXI master. It accepts one transaction at a time, read or write, INCR bursts of up to 16 beats, and converts it into SRAM CS/OE/WEB/A/DI accesses. AXI ID is returned unchanged so the interconnect can route responses.

## Interface
Parameters:
- SRAM_AW, 14 — SRAM word-address width (64 KB); word address = AxADDR[SRAM_AW+1:2].
- DATA_W, 32 — data width; equals `AXI_DATA_BITS.

Ports (name direction width meaning):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  `AXI_IDS_BITS/32/4/3/2/1  read address channel.
- ARREADY  out  1  read address accept.
- RID/RDATA/RRESP/RLAST/RVALID  out  `AXI_IDS_BITS/32/2/1/1  read data channel.
- RREADY  in  1  read data accept.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  `AXI_IDS_BITS/32/4/3/2/1  write address channel.
- AWREADY  out  1  write address accept.
- WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write data channel.
- WREADY  out  1  write data accept.
- BID/BRESP/BVALID  out  `AXI_IDS_BITS/2/1  write response.
- BREADY  in  1  response accept.
- CS, OE  out  1 each  SRAM chip select, output enable (active-high).
- WEB  out  32  SRAM per-bit write enable, active-low.
- A  out  SRAM_AW  SRAM word address.
- DI  out  32  SRAM write data.
- DO  in  32  SRAM read data; valid the cycle after a CS&OE access, held until the next CS access.

## Operation
- States: IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP. Reset → IDLE.
- IDLE: ARREADY = ~(SLV_WR_PRIO_EN & AWVALID). AWREADY = ~ARVALID without the macro, 1 with it. Exactly one handshake fires per cycle.
- On AR handshake: latch ARID, word address, ARLEN into a beat counter (cnt=0) → RD_ISSUE.
- RD_ISSUE: CS=1, OE=1, A=addr, WEB=all 1 → RD_DATA.
- RD_DATA: RVALID=1, RDATA=DO, RID=latched, RRESP=OKAY, RLAST=(cnt==len). On R handshake: if RLAST → IDLE, else cnt++, addr++ → RD_ISSUE. CS=0 in RD_DATA so DO stays stable under backpressure.
- On AW handshake: latch AWID, address, AWLEN; cnt=0; err=0 → WR_DATA.
- WR_DATA: WREADY=1. On W handshake (same cycle): CS=1, OE=0, A=addr, DI=WDATA, WEB[8i+7:8i]={8{~WSTRB[i]}}.
  - If WLAST or cnt==len → WR_RESP; err set if WLAST≠(cnt==len).
  - Otherwise cnt++, addr++.
- WR_RESP: BVALID=1, BID=latched, BRESP = err ? SLVERR(2'b10) : OKAY(2'b00). On B handshake → IDLE.
- ARBURST/AWBURST and AxSIZE ignored: always INCR, 4-byte beats. Word address increments modulo 2^SRAM_AW (wraps 0x3FFF→0x0000).
- Outside listed cases: CS=0, OE=0, WEB=all 1, A=latched addr, DI=0.

## Timing
- Reset values: ARREADY=1, AWREADY=1 (IDLE, no valids), RVALID=0, BVALID=0, WREADY=0, RLAST=0, RID=BID=0, RRESP=BRESP=0, RDATA=DO, CS=0, OE=0, WEB=all 1, A=0, DI=0.
- Read: AR handshake cycle T → RVALID at T+2. Each further beat takes 2 cycles after the R handshake. Single-beat read returns to IDLE at T+3 with zero-wait RREADY.
- Write: AW handshake at T → WREADY at T+1; one beat per cycle. SRAM write occurs in the W-handshake cycle. BVALID appears the cycle after the last beat.
- Valid outputs, once asserted, are held with stable payload until the handshake.
- rst asserted mid-burst: next cycle is IDLE with reset outputs. No B or R is issued for the aborted transaction. SRAM writes already performed stand.

## Configuration
- SLV_WR_PRIO_EN defined: simultaneous ARVALID and AWVALID in IDLE → write accepted first; read is taken after B completes.
- Not defined (default): read wins. AWREADY=0 while ARVALID=1 in IDLE.

## Test plan
- Single write then read: AW addr 0x0000_0010, WDATA 0xDEAD_BEEF, WSTRB 4'hF, WLAST=1 → A=4, WEB=0, BRESP=0. Read of 0x10 → RDATA 0xDEAD_BEEF, RLAST=1, RVALID at T+2.
- Partial strobe: WSTRB 4'b0101 → WEB=32'hFF00_FF00. Read-back merges the new bytes 0 and 2 with the old bytes.
- Burst read ARLEN=3 from word 0x3FFE with RREADY held low 3 cycles on beat 1 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001. RDATA stable while stalled; RLAST on 4th beat only.
- Simultaneous ARVALID/AWVALID in IDLE → ARREADY=1, AWREADY=0 (default); reversed with SLV_WR_PRIO_EN.
- AWLEN=3 with WLAST on beat 2 → write ends after beat 2, BRESP=2'b10. AWLEN=1 with no WLAST → ends after 2 beats, BRESP=2'b10.
- rst pulse during RD_DATA of a 4-beat burst → next cycle RVALID=0, CS=0, ARREADY=1. New read completes normally.
